ceas_alarma: RTL and testbench

CEAS_ALARMA -- requirements
Module: ceas_alarma

---
 rtl/ceas_pkg.sv | 38 +++
 rtl/tick_gen.sv | 33 +++
 rtl/ceas_alarma.sv | 190 +++++++++++++++++++
 tb/tb_ceas_alarma.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ceas_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ceas_pkg : mode encoding, time limits and helpers for the alarm clock    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package ceas_pkg;

    typedef enum logic [1:0] {
        MOD_RUN       = 2'd0,
        MOD_SET_TIME  = 2'd1,
        MOD_SET_ALARM = 2'd2
    } mod_t;

    localparam logic [4:0] MAX_ORE    = 5'd23;
    localparam logic [5:0] MAX_MIN    = 6'd59;
    localparam logic [5:0] MAX_SEC    = 6'd59;
    localparam logic [5:0] SNOOZE_MIN = 6'd5;

    function automatic logic [5:0] inc_wrap(input logic [5:0] val, input logic [5:0] max);
        return (val == max) ? 6'd0 : val + 6'd1;
    endfunction

    function automatic logic [4:0] inc_ore(input logic [4:0] val);
        return (val == MAX_ORE) ? 5'd0 : val + 5'd1;
    endfunction

    // Returns {ore, minute} of hh:mm plus the snooze interval, wrapping at 24 h.
    function automatic logic [10:0] snooze_target(input logic [4:0] h, input logic [5:0] m);
        logic [6:0] sum;
        sum = {1'b0, m} + {1'b0, SNOOZE_MIN};
        if (sum > {1'b0, MAX_MIN})
            return {inc_ore(h), 6'(sum - 7'd60)};
        else
            return {h, sum[5:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tick_gen : one-cycle tick every CLK_PER_SEC clocks, with clear and hold  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tick_gen #(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int              CW   = $clog2(CLK_PER_SEC);
    localparam logic [CW-1:0]   LAST = CW'(CLK_PER_SEC - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset || clear || hold)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + CW'(1);
    end

    assign tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/ceas_alarma.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ceas_alarma : 24 h clock with settable alarm; CEAS_SNOOZE_EN adds snooze |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ceas_alarma
    import ceas_pkg::*;
#(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       semnal_setare,
    input  logic       semnal_setare_a,
    input  logic       semnal_b1,
    input  logic       semnal_b2,
    input  logic       semnal_stop,
    input  logic       semnal_reset,
    output logic [4:0] ore,
    output logic [5:0] minute,
    output logic [5:0] secunde,
    output logic [4:0] ore_a,
    output logic [5:0] minute_a,
    output logic [1:0] mod,
    output logic       alarma_en,
    output logic       led
);

    mod_t       mode, mode_nxt;
    logic [4:0] ore_nxt, ore_a_nxt, adv_ore;
    logic [5:0] minute_nxt, secunde_nxt, minute_a_nxt, adv_min, adv_sec;
    logic       en_nxt, led_nxt;
    logic       tick, time_run, alarm_match;
    logic       mode_chg, stop_hit, snz_hit;
`ifdef CEAS_SNOOZE_EN
    logic       snz_vld, snz_vld_nxt;
    logic [4:0] snz_ore, snz_ore_nxt;
    logic [5:0] snz_min, snz_min_nxt;
`endif

    assign mod = mode;

    tick_gen #(.CLK_PER_SEC(CLK_PER_SEC)) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .clear (semnal_reset || (mode == MOD_SET_TIME && semnal_setare)),
        .hold  (mode == MOD_SET_TIME),
        .tick  (tick)
    );

    // Value the clock would hold after one more second.
    assign adv_sec  = inc_wrap(secunde, MAX_SEC);
    assign adv_min  = (secunde == MAX_SEC) ? inc_wrap(minute, MAX_MIN) : minute;
    assign adv_ore  = (secunde == MAX_SEC && minute == MAX_MIN) ? inc_ore(ore) : ore;
    assign time_run = tick && (mode != MOD_SET_TIME);
    assign alarm_match = (adv_ore == ore_a) && (adv_min == minute_a) && (adv_sec == 6'd0);

    always_comb begin
        mode_nxt     = mode;
        ore_nxt      = ore;
        minute_nxt   = minute;
        secunde_nxt  = secunde;
        ore_a_nxt    = ore_a;
        minute_a_nxt = minute_a;
        en_nxt       = alarma_en;
        led_nxt      = led;
        mode_chg     = 1'b0;
        stop_hit     = 1'b0;
        snz_hit      = 1'b0;
`ifdef CEAS_SNOOZE_EN
        snz_vld_nxt  = snz_vld;
        snz_ore_nxt  = snz_ore;
        snz_min_nxt  = snz_min;
`endif
        if (semnal_reset) begin
            mode_nxt    = MOD_RUN;
            ore_nxt     = 5'd0;
            minute_nxt  = 6'd0;
            secunde_nxt = 6'd0;
            led_nxt     = 1'b0;
        end else begin
            case (mode)
                MOD_SET_TIME: if (semnal_setare) begin
                    mode_nxt    = MOD_RUN;
                    secunde_nxt = 6'd0;
                    mode_chg    = 1'b1;
                end
                MOD_SET_ALARM: if (semnal_setare_a) begin
                    mode_nxt = MOD_RUN;
                    mode_chg = 1'b1;
                end
                default: if (semnal_setare) begin
                    mode_nxt = MOD_SET_TIME;
                    mode_chg = 1'b1;
                end else if (semnal_setare_a) begin
                    mode_nxt = MOD_SET_ALARM;
                    mode_chg = 1'b1;
                end
            endcase

            if (!mode_chg) begin
                case (mode)
                    MOD_SET_TIME: begin
                        if (semnal_b1) ore_nxt    = inc_ore(ore);
                        if (semnal_b2) minute_nxt = inc_wrap(minute, MAX_MIN);
                    end
                    MOD_SET_ALARM: begin
                        if (semnal_b1) ore_a_nxt    = inc_ore(ore_a);
                        if (semnal_b2) minute_a_nxt = inc_wrap(minute_a, MAX_MIN);
                    end
                    default: begin
`ifdef CEAS_SNOOZE_EN
                        if (semnal_b1 && led) begin
                            led_nxt     = 1'b0;
                            snz_hit     = 1'b1;
                            snz_vld_nxt = 1'b1;
                            {snz_ore_nxt, snz_min_nxt} = snooze_target(ore, minute);
                        end
`endif
                    end
                endcase

                // Stop silences a ringing alarm; otherwise it arms/disarms.
                if (semnal_stop) begin
                    stop_hit = 1'b1;
                    if (led) begin
                        led_nxt = 1'b0;
`ifdef CEAS_SNOOZE_EN
                        snz_vld_nxt = 1'b0;
`endif
                    end else begin
                        en_nxt = !alarma_en;
`ifdef CEAS_SNOOZE_EN
                        if (alarma_en) snz_vld_nxt = 1'b0;
`endif
                    end
                end
            end

            if (time_run) begin
                ore_nxt     = adv_ore;
                minute_nxt  = adv_min;
                secunde_nxt = adv_sec;
                if (en_nxt && !stop_hit && !snz_hit) begin
                    if (alarm_match) led_nxt = 1'b1;
`ifdef CEAS_SNOOZE_EN
                    if (snz_vld && adv_ore == snz_ore && adv_min == snz_min && adv_sec == 6'd0) begin
                        led_nxt     = 1'b1;
                        snz_vld_nxt = 1'b0;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mode      <= MOD_RUN;
            ore       <= 5'd0;
            minute    <= 6'd0;
            secunde   <= 6'd0;
            ore_a     <= 5'd0;
            minute_a  <= 6'd0;
            alarma_en <= 1'b0;
            led       <= 1'b0;
`ifdef CEAS_SNOOZE_EN
            snz_vld   <= 1'b0;
            snz_ore   <= 5'd0;
            snz_min   <= 6'd0;
`endif
        end else begin
            mode      <= mode_nxt;
            ore       <= ore_nxt;
            minute    <= minute_nxt;
            secunde   <= secunde_nxt;
            ore_a     <= ore_a_nxt;
            minute_a  <= minute_a_nxt;
            alarma_en <= en_nxt;
            led       <= led_nxt;
`ifdef CEAS_SNOOZE_EN
            snz_vld   <= snz_vld_nxt;
            snz_ore   <= snz_ore_nxt;
            snz_min   <= snz_min_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ceas_alarma.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ceas_alarma : scoreboard bench for ceas_alarma at CLK_PER_SEC=4       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ceas_alarma;

    localparam int CPS = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       semnal_setare = 1'b0, semnal_setare_a = 1'b0;
    logic       semnal_b1 = 1'b0, semnal_b2 = 1'b0;
    logic       semnal_stop = 1'b0, semnal_reset = 1'b0;
    logic [4:0] ore, ore_a;
    logic [5:0] minute, secunde, minute_a;
    logic [1:0] mod;
    logic       alarma_en, led;

    always #5 clock = ~clock;

    ceas_alarma #(.CLK_PER_SEC(CPS)) dut (
        .clock           (clock),
        .reset           (reset),
        .semnal_setare   (semnal_setare),
        .semnal_setare_a (semnal_setare_a),
        .semnal_b1       (semnal_b1),
        .semnal_b2       (semnal_b2),
        .semnal_stop     (semnal_stop),
        .semnal_reset    (semnal_reset),
        .ore             (ore),
        .minute          (minute),
        .secunde         (secunde),
        .ore_a           (ore_a),
        .minute_a        (minute_a),
        .mod             (mod),
        .alarma_en       (alarma_en),
        .led             (led)
    );

    typedef enum int {S_TIME, S_ALARM, S_MOD, S_EN, S_LED} sel_t;
    typedef struct {
        string       tag;
        sel_t        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [31:0] hms(input int h, input int m, input int s);
        return 32'(h * 4096 + m * 64 + s);
    endfunction

    function automatic logic [31:0] at_sec(input int t);
        int u;
        u = t % 86400;
        return hms(u / 3600, (u / 60) % 60, u % 60);
    endfunction

    function automatic logic [31:0] observe(input sel_t s);
        case (s)
            S_TIME:  return 32'({ore, minute, secunde});
            S_ALARM: return 32'({ore_a, minute_a});
            S_MOD:   return 32'(mod);
            S_EN:    return 32'(alarma_en);
            default: return 32'(led);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input sel_t sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // One clock edge; pulses are dropped and pending expectations compared.
    task automatic step();
        @(posedge clock);
        #1;
        semnal_setare = 1'b0; semnal_setare_a = 1'b0;
        semnal_b1 = 1'b0; semnal_b2 = 1'b0;
        semnal_stop = 1'b0; semnal_reset = 1'b0;
        drain();
    endtask

    task automatic press(input int n, input logic b1, input logic b2);
        repeat (n) begin
            semnal_b1 = b1;
            semnal_b2 = b2;
            step();
        end
    endtask

    task automatic expect_all_clear(input string tag);
        expect_out({tag, "_time"},  S_TIME,  32'd0);
        expect_out({tag, "_alarm"}, S_ALARM, 32'd0);
        expect_out({tag, "_mod"},   S_MOD,   32'd0);
        expect_out({tag, "_en"},    S_EN,    32'd0);
        expect_out({tag, "_led"},   S_LED,   32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        step();
        expect_all_clear("reset");
        step();
        reset = 1'b1;

        // Free run: one second every 4 cycles, 240 cycles = one minute
        for (int i = 1; i <= 240; i++) begin
            expect_out("run", S_TIME, at_sec(i / CPS));
            step();
        end

        // Set time to 23:59 exercising wraps
        semnal_setare = 1'b1;
        expect_out("enter_set_time", S_MOD, 32'd1);
        expect_out("enter_set_time_t", S_TIME, hms(0, 1, 0));
        step();
        press(23, 1'b1, 1'b1);
        expect_out("set_both", S_TIME, hms(23, 24, 0));
        step();
        press(35, 1'b0, 1'b1);
        semnal_b2 = 1'b1;
        expect_out("min_wrap_no_carry", S_TIME, hms(23, 0, 0));
        step();
        semnal_b1 = 1'b1;
        expect_out("hour_wrap", S_TIME, hms(0, 0, 0));
        step();
        press(23, 1'b1, 1'b0);
        press(59, 1'b0, 1'b1);
        repeat (8) step();
        expect_out("set_time_hold", S_TIME, hms(23, 59, 0));
        step();
        semnal_setare = 1'b1;
        expect_out("leave_set_time", S_MOD, 32'd0);
        step();
        for (int i = 1; i <= 240; i++) begin
            expect_out("midnight_run", S_TIME, at_sec(86340 + i / CPS));
            step();
        end

        // Alarm at 00:02 with mode/stop handling
        semnal_reset = 1'b1;
        expect_out("sreset_time", S_TIME, 32'd0);
        step();
        semnal_setare_a = 1'b1;
        expect_out("enter_set_alarm", S_MOD, 32'd2);
        step();
        semnal_setare = 1'b1;
        expect_out("ignore_other_mode", S_MOD, 32'd2);
        step();
        press(1, 1'b0, 1'b1);
        semnal_b2 = 1'b1;
        expect_out("alarm_min", S_ALARM, 32'd2);
        expect_out("tick_in_set_alarm", S_TIME, at_sec(1));
        step();
        semnal_setare_a = 1'b1; semnal_b2 = 1'b1;
        expect_out("leave_set_alarm", S_MOD, 32'd0);
        expect_out("inc_dropped", S_ALARM, 32'd2);
        step();
        semnal_b1 = 1'b1; semnal_b2 = 1'b1;
        expect_out("run_btn_ignored", S_TIME, at_sec(1));
        expect_out("run_btn_alarm", S_ALARM, 32'd2);
        step();
        semnal_stop = 1'b1;
        expect_out("stop_arm", S_EN, 32'd1);
        step();
        semnal_stop = 1'b1;
        expect_out("stop_disarm", S_EN, 32'd0);
        step();
        semnal_stop = 1'b1;
        expect_out("stop_rearm", S_EN, 32'd1);
        step();
        for (int k = 10; k <= 480; k++) begin
            expect_out("ring_time", S_TIME, at_sec(k / CPS));
            expect_out("ring_led", S_LED, (k >= 480) ? 32'd1 : 32'd0);
            step();
        end
        semnal_stop = 1'b1;
        expect_out("silence_led", S_LED, 32'd0);
        expect_out("silence_en", S_EN, 32'd1);
        step();

        // semnal_reset beats a coincident increment in SET_TIME
        semnal_reset = 1'b1;
        step();
        semnal_setare = 1'b1;
        step();
        press(5, 1'b1, 1'b0);
        press(30, 1'b0, 1'b1);
        expect_out("at_0530", S_TIME, hms(5, 30, 0));
        step();
        semnal_reset = 1'b1; semnal_b2 = 1'b1;
        expect_out("sreset_over_inc", S_TIME, 32'd0);
        expect_out("sreset_mod", S_MOD, 32'd0);
        expect_out("sreset_alarm_kept", S_ALARM, 32'd2);
        expect_out("sreset_en_kept", S_EN, 32'd1);
        step();

        // Alarm 07:00, time 06:59, then snooze behaviour
        semnal_setare_a = 1'b1;
        step();
        press(7, 1'b1, 1'b0);
        press(58, 1'b0, 1'b1);
        semnal_setare_a = 1'b1;
        expect_out("alarm_0700", S_ALARM, 32'(7 * 64));
        step();
        semnal_reset = 1'b1;
        step();
        semnal_setare = 1'b1;
        step();
        press(6, 1'b1, 1'b0);
        press(59, 1'b0, 1'b1);
        semnal_setare = 1'b1;
        expect_out("at_0659", S_TIME, hms(6, 59, 0));
        step();
        for (int k = 1; k <= 240; k++) begin
            expect_out("to_0700", S_TIME, at_sec(25140 + k / CPS));
            expect_out("to_0700_led", S_LED, (k >= 240) ? 32'd1 : 32'd0);
            step();
        end
        semnal_b1 = 1'b1;
`ifdef CEAS_SNOOZE_EN
        expect_out("snooze_press", S_LED, 32'd0);
`else
        expect_out("snooze_press", S_LED, 32'd1);
`endif
        step();
        for (int k = 242; k <= 1440; k++) begin
`ifdef CEAS_SNOOZE_EN
            expect_out("snooze_led", S_LED, (k >= 1440) ? 32'd1 : 32'd0);
`else
            expect_out("snooze_led", S_LED, 32'd1);
`endif
            if (k == 1440) expect_out("at_0705", S_TIME, hms(7, 5, 0));
            step();
        end
        semnal_stop = 1'b1;
        expect_out("final_stop", S_LED, 32'd0);
        step();

        // Hard reset mid-set, then first tick timing
        semnal_setare_a = 1'b1;
        expect_out("pre_reset_mode", S_MOD, 32'd2);
        step();
        reset = 1'b0;
        expect_all_clear("mid_reset");
        step();
        reset = 1'b1;
        for (int i = 1; i <= CPS; i++) begin
            expect_out("first_tick", S_TIME, at_sec(i / CPS));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
